// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the 2-read/1-write register file with busy scoreboard.
package regfile_pkg;

    localparam int REGFILE_WIDTH = 16;
    localparam int REGFILE_DEPTH = 8;

    // True when a read port must take the in-flight write data instead of storage.
    function automatic logic bypass_sel(input logic        wr_en,
                                        input int unsigned wr_addr,
                                        input int unsigned rd_addr,
                                        input logic        zero_reg);
        return wr_en && (wr_addr == rd_addr) && !(zero_reg && (rd_addr == 0));
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy flags: reserved by the decoder, released by write-back.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int DEPTH    = REGFILE_DEPTH,
    parameter bit ZERO_REG = 1'b0,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic             rsv_en,
    input  logic [AW-1:0]    rsv_addr,
    input  logic [AW-1:0]    rd_addr_a,
    input  logic [AW-1:0]    rd_addr_b,
    output logic             rsv_ok,
    output logic             busy_a,
    output logic             busy_b,
    output logic [DEPTH-1:0] busy_vec
);

    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_d;
    logic             rsv_zero;

    assign rsv_zero = ZERO_REG && (rsv_addr == '0);

    // A release landing on the requested register this cycle frees it for the new reservation.
    assign rsv_ok = rsv_en
                    && (!busy_q[rsv_addr] || (wr_en && (wr_addr == rsv_addr)))
                    && !rsv_zero;

    always_comb begin
        busy_d = busy_q;
        if (wr_en) begin
            busy_d[wr_addr] = 1'b0;
        end
        if (rsv_ok) begin
            busy_d[rsv_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_a   = busy_q[rd_addr_a] && !(wr_en && (wr_addr == rd_addr_a));
    assign busy_b   = busy_q[rd_addr_b] && !(wr_en && (wr_addr == rd_addr_b));
    assign busy_vec = busy_q;

endmodule

// File: rtl/regfile_2r1w_sb.sv
// Register file: two combinational read ports with write-through bypass, one write port,
// and a reserve/release busy scoreboard between decoder and datapath.
module regfile_2r1w_sb
    import regfile_pkg::*;
#(
    parameter int WIDTH    = REGFILE_WIDTH,
    parameter int DEPTH    = REGFILE_DEPTH,
    parameter bit ZERO_REG = 1'b0,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr_a,
    output logic [WIDTH-1:0] rd_data_a,
    output logic             busy_a,
    input  logic [AW-1:0]    rd_addr_b,
    output logic [WIDTH-1:0] rd_data_b,
    output logic             busy_b,
    input  logic             rsv_en,
    input  logic [AW-1:0]    rsv_addr,
    output logic             rsv_ok,
    output logic [DEPTH-1:0] busy_vec
);

    // Flop array rather than RAM so that reset can clear every entry at once.
    logic [WIDTH-1:0] mem [DEPTH];
    logic             wr_store;
    logic             byp_a;
    logic             byp_b;

    assign wr_store = wr_en && !(ZERO_REG && (wr_addr == '0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_store) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign byp_a = bypass_sel(wr_en, 32'(wr_addr), 32'(rd_addr_a), ZERO_REG);
    assign byp_b = bypass_sel(wr_en, 32'(wr_addr), 32'(rd_addr_b), ZERO_REG);

    assign rd_data_a = byp_a ? wr_data : mem[rd_addr_a];
    assign rd_data_b = byp_b ? wr_data : mem[rd_addr_b];

    regfile_scoreboard #(
        .DEPTH    (DEPTH),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .rsv_en    (rsv_en),
        .rsv_addr  (rsv_addr),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .rsv_ok    (rsv_ok),
        .busy_a    (busy_a),
        .busy_b    (busy_b),
        .busy_vec  (busy_vec)
    );

endmodule

// File: tb/tb_regfile_2r1w_sb.sv
// Directed bench: vector table on the default build plus hand sequences for reset,
// the hard-wired zero register and a 32x16 build.
module tb_regfile_2r1w_sb;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // default build: 16 x 8, no zero register
    logic        m_wr_en = 0, m_rsv_en = 0;
    logic [2:0]  m_wr_addr = 0, m_ra = 0, m_rb = 0, m_rsv_addr = 0;
    logic [15:0] m_wr_data = 0, m_rd_a, m_rd_b;
    logic        m_busy_a, m_busy_b, m_rsv_ok;
    logic [7:0]  m_vec;

    regfile_2r1w_sb #(.WIDTH(16), .DEPTH(8), .ZERO_REG(1'b0)) u_dut (
        .clk(clk), .rst_n(rst_n), .wr_en(m_wr_en), .wr_addr(m_wr_addr), .wr_data(m_wr_data),
        .rd_addr_a(m_ra), .rd_data_a(m_rd_a), .busy_a(m_busy_a),
        .rd_addr_b(m_rb), .rd_data_b(m_rd_b), .busy_b(m_busy_b),
        .rsv_en(m_rsv_en), .rsv_addr(m_rsv_addr), .rsv_ok(m_rsv_ok), .busy_vec(m_vec)
    );

    // zero-register build
    logic        z_wr_en = 0, z_rsv_en = 0;
    logic [2:0]  z_wr_addr = 0, z_ra = 0, z_rb = 0, z_rsv_addr = 0;
    logic [15:0] z_wr_data = 0, z_rd_a, z_rd_b;
    logic        z_busy_a, z_busy_b, z_rsv_ok;
    logic [7:0]  z_vec;

    regfile_2r1w_sb #(.WIDTH(16), .DEPTH(8), .ZERO_REG(1'b1)) u_dut_zero (
        .clk(clk), .rst_n(rst_n), .wr_en(z_wr_en), .wr_addr(z_wr_addr), .wr_data(z_wr_data),
        .rd_addr_a(z_ra), .rd_data_a(z_rd_a), .busy_a(z_busy_a),
        .rd_addr_b(z_rb), .rd_data_b(z_rd_b), .busy_b(z_busy_b),
        .rsv_en(z_rsv_en), .rsv_addr(z_rsv_addr), .rsv_ok(z_rsv_ok), .busy_vec(z_vec)
    );

    // wide build: 32 x 16
    logic        w_wr_en = 0, w_rsv_en = 0;
    logic [3:0]  w_wr_addr = 0, w_ra = 0, w_rb = 0, w_rsv_addr = 0;
    logic [31:0] w_wr_data = 0, w_rd_a, w_rd_b;
    logic        w_busy_a, w_busy_b, w_rsv_ok;
    logic [15:0] w_vec;

    regfile_2r1w_sb #(.WIDTH(32), .DEPTH(16), .ZERO_REG(1'b0)) u_dut_wide (
        .clk(clk), .rst_n(rst_n), .wr_en(w_wr_en), .wr_addr(w_wr_addr), .wr_data(w_wr_data),
        .rd_addr_a(w_ra), .rd_data_a(w_rd_a), .busy_a(w_busy_a),
        .rd_addr_b(w_rb), .rd_data_b(w_rd_b), .busy_b(w_busy_b),
        .rsv_en(w_rsv_en), .rsv_addr(w_rsv_addr), .rsv_ok(w_rsv_ok), .busy_vec(w_vec)
    );

    typedef struct {
        logic        wr_en;
        logic [2:0]  wr_addr;
        logic [15:0] wr_data;
        logic [2:0]  ra;
        logic [2:0]  rb;
        logic        rsv_en;
        logic [2:0]  rsv_addr;
        logic [15:0] exp_a;
        logic [15:0] exp_b;
        logic        exp_ba;
        logic        exp_bb;
        logic        exp_ok;
        logic [7:0]  exp_vec;
    } vec_t;

    vec_t tbl [17];

    function automatic vec_t mk(logic we, logic [2:0] wa, logic [15:0] wd,
                                logic [2:0] ra, logic [2:0] rb, logic re, logic [2:0] rsa,
                                logic [15:0] ea, logic [15:0] eb, logic eba, logic ebb,
                                logic eok, logic [7:0] evec);
        vec_t v;
        v.wr_en = we;  v.wr_addr = wa;  v.wr_data = wd;
        v.ra = ra;     v.rb = rb;       v.rsv_en = re;   v.rsv_addr = rsa;
        v.exp_a = ea;  v.exp_b = eb;    v.exp_ba = eba;  v.exp_bb = ebb;
        v.exp_ok = eok; v.exp_vec = evec;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s[%0d]: got %h, expected %h", name, idx, act, exp);
        end
    endtask

    function automatic logic [31:0] pat(input int i);
        return 32'hA5C3_0000 ^ (32'(i) * 32'h0101_0101) ^ 32'(i << 4);
    endfunction

    initial begin
        //            we wa  wd        ra rb re rsa  exp_a     exp_b     ba bb ok vec
        tbl[0]  = mk(0, 0, 16'h0000, 0, 7, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 8'h00);
        tbl[1]  = mk(1, 3, 16'hBEEF, 3, 5, 0, 0, 16'hBEEF, 16'h0000, 0, 0, 0, 8'h00);
        tbl[2]  = mk(0, 0, 16'h0000, 3, 3, 0, 0, 16'hBEEF, 16'hBEEF, 0, 0, 0, 8'h00);
        tbl[3]  = mk(0, 0, 16'h0000, 2, 0, 1, 2, 16'h0000, 16'h0000, 0, 0, 1, 8'h00);
        tbl[4]  = mk(0, 0, 16'h0000, 2, 2, 1, 2, 16'h0000, 16'h0000, 1, 1, 0, 8'h04);
        tbl[5]  = mk(1, 2, 16'h1234, 2, 2, 0, 0, 16'h1234, 16'h1234, 0, 0, 0, 8'h04);
        tbl[6]  = mk(0, 0, 16'h0000, 2, 3, 0, 0, 16'h1234, 16'hBEEF, 0, 0, 0, 8'h00);
        tbl[7]  = mk(0, 0, 16'h0000, 6, 5, 1, 6, 16'h0000, 16'h0000, 0, 0, 1, 8'h00);
        tbl[8]  = mk(1, 6, 16'h5A5A, 6, 3, 1, 6, 16'h5A5A, 16'hBEEF, 0, 0, 1, 8'h40);
        tbl[9]  = mk(0, 0, 16'h0000, 6, 0, 0, 0, 16'h5A5A, 16'h0000, 1, 0, 0, 8'h40);
        tbl[10] = mk(0, 0, 16'h0000, 6, 6, 0, 0, 16'h5A5A, 16'h5A5A, 1, 1, 0, 8'h40);
        tbl[11] = mk(1, 5, 16'h0001, 5, 6, 0, 0, 16'h0001, 16'h5A5A, 0, 1, 0, 8'h40);
        tbl[12] = mk(0, 0, 16'h0000, 5, 6, 1, 6, 16'h0001, 16'h5A5A, 0, 1, 0, 8'h40);
        tbl[13] = mk(1, 6, 16'hC0DE, 6, 1, 1, 1, 16'hC0DE, 16'h0000, 0, 0, 1, 8'h40);
        tbl[14] = mk(0, 0, 16'h0000, 6, 1, 0, 0, 16'hC0DE, 16'h0000, 0, 1, 0, 8'h02);
        tbl[15] = mk(1, 1, 16'hFFFF, 1, 0, 0, 0, 16'hFFFF, 16'h0000, 0, 0, 0, 8'h02);
        tbl[16] = mk(0, 0, 16'h0000, 1, 7, 0, 0, 16'hFFFF, 16'h0000, 0, 0, 0, 8'h00);

        // reset state on the default build, while rst_n is held low
        #1;
        chk("rst_vec", 0, 32'(m_vec), 32'h0);
        for (int i = 0; i < 8; i++) begin
            m_ra = 3'(i);
            m_rb = 3'(7 - i);
            #1;
            chk("rst_rd_a", i, 32'(m_rd_a), 32'h0);
            chk("rst_rd_b", i, 32'(m_rd_b), 32'h0);
            chk("rst_busy_a", i, 32'(m_busy_a), 32'h0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // table-driven vectors
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            m_wr_en = tbl[i].wr_en;   m_wr_addr = tbl[i].wr_addr; m_wr_data = tbl[i].wr_data;
            m_ra = tbl[i].ra;         m_rb = tbl[i].rb;
            m_rsv_en = tbl[i].rsv_en; m_rsv_addr = tbl[i].rsv_addr;
            #1;
            chk("rd_a", i, 32'(m_rd_a), 32'(tbl[i].exp_a));
            chk("rd_b", i, 32'(m_rd_b), 32'(tbl[i].exp_b));
            chk("busy_a", i, 32'(m_busy_a), 32'(tbl[i].exp_ba));
            chk("busy_b", i, 32'(m_busy_b), 32'(tbl[i].exp_bb));
            chk("rsv_ok", i, 32'(m_rsv_ok), 32'(tbl[i].exp_ok));
            chk("busy_vec", i, 32'(m_vec), 32'(tbl[i].exp_vec));
        end
        @(negedge clk);
        m_wr_en = 0; m_rsv_en = 0;

        // zero register: writes ignored, never reservable
        z_wr_en = 1; z_wr_addr = 0; z_wr_data = 16'hFFFF; z_ra = 0; z_rb = 0;
        z_rsv_en = 1; z_rsv_addr = 0;
        #1;
        chk("z_rd_a_byp", 0, 32'(z_rd_a), 32'h0);
        chk("z_rsv_ok", 0, 32'(z_rsv_ok), 32'h0);
        @(negedge clk);
        z_wr_addr = 1; z_wr_data = 16'h00AA; z_ra = 0; z_rb = 1; z_rsv_en = 0;
        #1;
        chk("z_rd_a", 1, 32'(z_rd_a), 32'h0);
        chk("z_rd_b_byp", 1, 32'(z_rd_b), 32'h00AA);
        chk("z_busy_a", 1, 32'(z_busy_a), 32'h0);
        chk("z_vec", 1, 32'(z_vec), 32'h0);
        @(negedge clk);
        z_wr_en = 0;
        #1;
        chk("z_rd_b", 2, 32'(z_rd_b), 32'h00AA);

        // wide build: fill, read back on both ports, reserve the top register
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            w_wr_en = 1; w_wr_addr = 4'(i); w_wr_data = pat(i);
        end
        @(negedge clk);
        w_wr_en = 0;
        for (int i = 0; i < 16; i++) begin
            w_ra = 4'(i);
            w_rb = 4'(15 - i);
            #1;
            chk("w_rd_a", i, w_rd_a, pat(i));
            chk("w_rd_b", i, w_rd_b, pat(15 - i));
        end
        @(negedge clk);
        w_rsv_en = 1; w_rsv_addr = 4'd15;
        #1;
        chk("w_rsv_ok", 0, 32'(w_rsv_ok), 32'h1);
        @(negedge clk);
        w_rsv_en = 0;
        #1;
        chk("w_vec", 0, 32'(w_vec), 32'h8000);

        // asynchronous reset in the middle of a write burst with a reservation pending
        @(negedge clk);
        m_wr_en = 1; m_wr_addr = 1; m_wr_data = 16'h1111; m_rsv_en = 1; m_rsv_addr = 4;
        @(negedge clk);
        m_rsv_en = 0; m_wr_addr = 2; m_wr_data = 16'h2222;
        m_ra = 1; m_rb = 4;
        #1;
        chk("mb_rd_a", 0, 32'(m_rd_a), 32'h1111);
        chk("mb_vec", 0, 32'(m_vec), 32'h10);
        @(negedge clk);
        m_wr_addr = 3; m_wr_data = 16'h3333;
        #2;
        m_wr_en = 0;
        rst_n = 1'b0;
        m_ra = 1; m_rb = 2;
        #1;
        chk("mb_rst_vec", 1, 32'(m_vec), 32'h0);
        chk("mb_rst_rd_a", 1, 32'(m_rd_a), 32'h0);
        chk("mb_rst_rd_b", 1, 32'(m_rd_b), 32'h0);
        for (int i = 0; i < 8; i++) begin
            m_ra = 3'(i);
            m_rb = 3'(7 - i);
            #1;
            chk("mb_rst_all_a", i, 32'(m_rd_a), 32'h0);
            chk("mb_rst_all_b", i, 32'(m_rd_b), 32'h0);
        end
        chk("w_rst_vec", 0, 32'(w_vec), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
